// File: rtl/xtea_arbiter.sv
// Round-robin arbiter sharing one xtea_top engine between two requesters.
// Define XTEA_ARB_TIMEOUT_EN to abort a stalled engine operation after TIMEOUT_CYCLES in WAIT.
module xtea_arbiter
`ifdef XTEA_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
)
`endif
(
    input  logic         clock,
    input  logic         reset_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         cfg0,
    input  logic         cfg1,
    input  logic [127:0] data0_i,
    input  logic [127:0] data1_i,
    input  logic [127:0] key0,
    input  logic [127:0] key1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [127:0] data0_o,
    output logic [127:0] data1_o,
`ifdef XTEA_ARB_TIMEOUT_EN
    output logic         err0,
    output logic         err1,
`endif
    output logic         eng_start,
    output logic         eng_cfg,
    output logic [127:0] eng_data_i,
    output logic [127:0] eng_key,
    input  logic         eng_busy,
    input  logic         eng_ready,
    input  logic [127:0] eng_data_o,
    output logic         busy,
    output logic         owner
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } state_e;

    state_e         state_q;
    state_e         state_d;
    logic           grantValid;
    logic           grantPort;
    logic           owner_q;
    logic           rrLast_q;
    logic           gntPulse_q;
    logic           cfgLatch_q;
    logic [127:0]   dataLatch_q;
    logic [127:0]   keyLatch_q;
    logic [127:0]   result0_q;
    logic [127:0]   result1_q;
`ifdef XTEA_ARB_TIMEOUT_EN
    logic [TO_W-1:0] toCnt_q;
    logic            timedOut_q;
    logic            toFire;
`endif

    always_comb begin
        state_d    = state_q;
        grantValid = 1'b0;
        grantPort  = 1'b0;
        eng_start  = 1'b0;
`ifdef XTEA_ARB_TIMEOUT_EN
        toFire     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // rrLast_q resets to 1 so simultaneous requests after reset favour port 0
                if (req0 && req1) begin
                    grantValid = 1'b1;
                    grantPort  = ~rrLast_q;
                end else if (req0) begin
                    grantValid = 1'b1;
                    grantPort  = 1'b0;
                end else if (req1) begin
                    grantValid = 1'b1;
                    grantPort  = 1'b1;
                end
                if (grantValid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!eng_busy) begin
                    eng_start = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (eng_ready) begin
                    state_d = CAPTURE;
                end
`ifdef XTEA_ARB_TIMEOUT_EN
                else if (toCnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    toFire  = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            CAPTURE: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rrLast_q    <= 1'b1;
            gntPulse_q  <= 1'b0;
            cfgLatch_q  <= 1'b0;
            dataLatch_q <= '0;
            keyLatch_q  <= '0;
            result0_q   <= '0;
            result1_q   <= '0;
`ifdef XTEA_ARB_TIMEOUT_EN
            toCnt_q     <= '0;
            timedOut_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gntPulse_q <= grantValid;
            if (grantValid) begin
                owner_q     <= grantPort;
                cfgLatch_q  <= grantPort ? cfg1 : cfg0;
                dataLatch_q <= grantPort ? data1_i : data0_i;
                keyLatch_q  <= grantPort ? key1 : key0;
            end
            if (state_q == CAPTURE) begin
                if (owner_q) begin
                    result1_q <= eng_data_o;
                end else begin
                    result0_q <= eng_data_o;
                end
            end
            if (state_q == DONE) begin
                rrLast_q <= owner_q;
            end
`ifdef XTEA_ARB_TIMEOUT_EN
            if (grantValid) begin
                timedOut_q <= 1'b0;
            end
            if (toFire) begin
                timedOut_q <= 1'b1;
                if (owner_q) begin
                    result1_q <= '0;
                end else begin
                    result0_q <= '0;
                end
            end
            if (state_q == ISSUE) begin
                toCnt_q <= '0;
            end else if (state_q == WAIT) begin
                toCnt_q <= toCnt_q + TO_W'(1);
            end
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;
    assign gnt0       = gntPulse_q & ~owner_q;
    assign gnt1       = gntPulse_q & owner_q;
    assign done0      = (state_q == DONE) & ~owner_q;
    assign done1      = (state_q == DONE) & owner_q;
    assign data0_o    = result0_q;
    assign data1_o    = result1_q;
    assign eng_cfg    = cfgLatch_q;
    assign eng_data_i = dataLatch_q;
    assign eng_key    = keyLatch_q;
`ifdef XTEA_ARB_TIMEOUT_EN
    assign err0       = done0 & timedOut_q;
    assign err1       = done1 & timedOut_q;
`endif

endmodule

// File: tb/tb_xtea_arbiter.sv
// Scoreboard bench for xtea_arbiter with a behavioural XTEA engine (128-bit block = two 64-bit XTEA blocks).
// Build with XTEA_ARB_TIMEOUT_EN defined to also exercise the WAIT timeout abort.
module tb_xtea_arbiter;

    localparam logic [31:0] DELTA = 32'h9E3779B9;

    logic         clock;
    logic         reset_n;
    logic         req0, req1, cfg0, cfg1;
    logic [127:0] data0In, data1In, key0, key1;
    logic         gnt0, gnt1, done0, done1;
    logic [127:0] data0Out, data1Out;
`ifdef XTEA_ARB_TIMEOUT_EN
    logic         err0, err1;
`endif
    logic         engStart, engCfg;
    logic [127:0] engDataIn, engKey, engDataOut;
    logic         engBusy, engReady, engBusyModel, extBusy;
    logic         busy, owner;

    int  testsRun    = 0;
    int  testsFailed = 0;
    int  startCount  = 0;
    int  engLatency  = 3;
    bit  engHang     = 1'b0;

    typedef struct {
        logic         port;
        logic [127:0] data;
        logic         err;
    } expect_t;
    expect_t expQ[$];

    assign engBusy = engBusyModel | extBusy;

`ifdef XTEA_ARB_TIMEOUT_EN
    xtea_arbiter #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
`else
    xtea_arbiter dut (
`endif
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .cfg0(cfg0), .cfg1(cfg1),
        .data0_i(data0In), .data1_i(data1In), .key0(key0), .key1(key1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .data0_o(data0Out), .data1_o(data1Out),
`ifdef XTEA_ARB_TIMEOUT_EN
        .err0(err0), .err1(err1),
`endif
        .eng_start(engStart), .eng_cfg(engCfg), .eng_data_i(engDataIn), .eng_key(engKey),
        .eng_busy(engBusy), .eng_ready(engReady), .eng_data_o(engDataOut),
        .busy(busy), .owner(owner)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] xteaBlock(input logic enc, input logic [63:0] blk, input logic [127:0] key);
        logic [31:0] v0, v1, sum;
        logic [31:0] k [4];
        for (int i = 0; i < 4; i++) k[i] = key[127 - 32*i -: 32];
        v0 = blk[63:32];
        v1 = blk[31:0];
        if (enc) begin
            sum = 32'h0;
            for (int r = 0; r < 32; r++) begin
                v0  = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]));
                sum = sum + DELTA;
                v1  = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]));
            end
        end else begin
            sum = 32'hC6EF3720;
            for (int r = 0; r < 32; r++) begin
                v1  = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]));
                sum = sum - DELTA;
                v0  = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]));
            end
        end
        return {v0, v1};
    endfunction

    function automatic logic [127:0] xteaModel(input logic enc, input logic [127:0] blk, input logic [127:0] key);
        return {xteaBlock(enc, blk[127:64], key), xteaBlock(enc, blk[63:0], key)};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input logic port, input logic [127:0] data, input logic err);
        expect_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        expQ.push_back(e);
    endtask

    // Engine model: result appears on eng_data_o only in the cycle after eng_ready.
    initial begin
        logic [127:0] res;
        engReady     = 1'b0;
        engBusyModel = 1'b0;
        engDataOut   = '0;
        forever begin
            @(negedge clock);
            if (engStart === 1'b1) begin
                startCount++;
                res = xteaModel(engCfg, engDataIn, engKey);
                if (!engHang) begin
                    @(posedge clock); #1;
                    engBusyModel = 1'b1;
                    repeat (engLatency) begin
                        @(posedge clock); #1;
                    end
                    engReady   = 1'b1;
                    engDataOut = ~res;
                    @(posedge clock); #1;
                    engReady     = 1'b0;
                    engBusyModel = 1'b0;
                    engDataOut   = res;
                end
            end
        end
    end

    initial begin
        expect_t      e;
        logic [127:0] prev0, prev1;
        prev0 = '0;
        prev1 = '0;
        forever begin
            @(negedge clock);
            if (engStart === 1'b1) checkOutput("start while engine busy", 128'(engBusy), '0);
            if (done0 || done1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected done", 128'({done1, done0}), '0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done port", 128'({done1, done0}), e.port ? 128'd2 : 128'd1);
                    checkOutput("result", e.port ? data1Out : data0Out, e.data);
                    checkOutput("other port result held", e.port ? data0Out : data1Out, e.port ? prev0 : prev1);
`ifdef XTEA_ARB_TIMEOUT_EN
                    checkOutput("err pulse", 128'({err1, err0}), e.err ? (e.port ? 128'd2 : 128'd1) : 128'd0);
`endif
                end
            end
            prev0 = data0Out;
            prev1 = data1Out;
        end
    end

    task automatic applyStimulus(input logic port, input logic cfg, input logic [127:0] data,
                                 input logic [127:0] key, output int lat, output logic startAtGnt);
        bit seen;
        seen       = 1'b0;
        lat        = -1;
        startAtGnt = 1'b0;
        if (port) begin
            req1 = 1'b1; cfg1 = cfg; data1In = data; key1 = key;
        end else begin
            req0 = 1'b1; cfg0 = cfg; data0In = data; key0 = key;
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if ((port ? gnt1 : gnt0) === 1'b1) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
        end
        checkOutput($sformatf("gnt%0d seen", port), 128'(seen), 128'd1);
        if (seen) begin
            startAtGnt = engStart;
            checkOutput("owner at grant", 128'(owner), 128'(port));
            checkOutput("busy at grant", 128'(busy), 128'd1);
        end
        if (port) begin
            req1 = 1'b0; cfg1 = ~cfg; data1In = ~data; key1 = ~key;
        end else begin
            req0 = 1'b0; cfg0 = ~cfg; data0In = ~data; key0 = ~key;
        end
        @(negedge clock);
        checkOutput("grant pulse width", 128'(port ? gnt1 : gnt0), '0);
    endtask

    task automatic waitIdle();
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            if (expQ.size() == 0 && !busy) break;
        end
        checkOutput("scoreboard drained", 128'(expQ.size()), '0);
        @(posedge clock); #1;
    endtask

    task automatic runPair(input logic firstPort, input logic [127:0] d0, input logic [127:0] k0,
                           input logic [127:0] d1, input logic [127:0] k1);
        int   l0, l1;
        logic s0, s1;
        if (firstPort) begin
            pushExpect(1'b1, xteaModel(1'b0, d1, k1), 1'b0);
            pushExpect(1'b0, xteaModel(1'b1, d0, k0), 1'b0);
        end else begin
            pushExpect(1'b0, xteaModel(1'b1, d0, k0), 1'b0);
            pushExpect(1'b1, xteaModel(1'b0, d1, k1), 1'b0);
        end
        fork
            applyStimulus(1'b0, 1'b1, d0, k0, l0, s0);
            applyStimulus(1'b1, 1'b0, d1, k1, l1, s1);
        join
        checkOutput("winner grant latency", 128'(firstPort ? l1 : l0), 128'd1);
        checkOutput("winner started at grant", 128'(firstPort ? s1 : s0), 128'd1);
        waitIdle();
    endtask

    initial begin
        int           lat, doneLat, expStarts;
        logic         st;
        logic [127:0] plain, keyE, cipher, dB, kB;
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; cfg0 = 1'b0; cfg1 = 1'b0;
        data0In = '0; data1In = '0; key0 = '0; key1 = '0;
        extBusy = 1'b0;
        expStarts = 0;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset control outputs", 128'({gnt0, gnt1, done0, done1, busy, owner, engStart, engCfg}), '0);
        checkOutput("reset data0_o", data0Out, '0);
        checkOutput("reset data1_o", data1Out, '0);
        checkOutput("reset eng operands", engDataIn | engKey, '0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        pushExpect(1'b0, xteaModel(1'b1, '0, '0), 1'b0);
        applyStimulus(1'b0, 1'b1, '0, '0, lat, st);
        expStarts++;
        checkOutput("gnt0 latency", 128'(lat), 128'd1);
        checkOutput("start with grant", 128'(st), 128'd1);
        checkOutput("start single cycle", 128'(engStart), '0);
        doneLat = -1;
        for (int c = 1; c < 100; c++) begin
            @(negedge clock);
            if (done0) begin
                doneLat = c;
                break;
            end
        end
        checkOutput("done latency", 128'(doneLat), 128'(engLatency + 2));
        waitIdle();

        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        runPair(1'b0, rand128(), rand128(), rand128(), rand128());
        expStarts += 2;

        plain = 128'h0123456789ABCDEF_FEDCBA9876543210;
        keyE  = rand128();
        pushExpect(1'b1, xteaModel(1'b1, plain, keyE), 1'b0);
        applyStimulus(1'b1, 1'b1, plain, keyE, lat, st);
        waitIdle();
        cipher = data1Out;
        pushExpect(1'b0, plain, 1'b0);
        applyStimulus(1'b0, 1'b0, cipher, keyE, lat, st);
        waitIdle();
        expStarts += 2;

        runPair(1'b1, rand128(), rand128(), rand128(), rand128());
        expStarts += 2;

        dB = rand128();
        kB = rand128();
        extBusy = 1'b1;
        pushExpect(1'b0, xteaModel(1'b1, dB, kB), 1'b0);
        applyStimulus(1'b0, 1'b1, dB, kB, lat, st);
        checkOutput("start held at grant", 128'(st), '0);
        repeat (3) begin
            @(negedge clock);
            checkOutput("start held while busy", 128'(engStart), '0);
        end
        @(posedge clock); #1;
        extBusy = 1'b0;
        @(negedge clock);
        checkOutput("start after busy drops", 128'(engStart), 128'd1);
        @(negedge clock);
        checkOutput("delayed start single cycle", 128'(engStart), '0);
        waitIdle();
        expStarts++;

        engLatency = 20;
        applyStimulus(1'b0, 1'b1, rand128(), rand128(), lat, st);
        expStarts++;
        repeat (2) @(negedge clock);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        checkOutput("reset mid-op busy/done/owner", 128'({busy, done0, done1, owner}), '0);
        checkOutput("reset mid-op data0_o", data0Out, '0);
        checkOutput("reset mid-op data1_o", data1Out, '0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (30) @(posedge clock);
        #1;
        engLatency = 3;
        runPair(1'b0, rand128(), rand128(), rand128(), rand128());
        expStarts += 2;

`ifdef XTEA_ARB_TIMEOUT_EN
        engHang = 1'b1;
        pushExpect(1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b1, rand128(), rand128(), lat, st);
        expStarts++;
        doneLat = -1;
        for (int c = 1; c < 100; c++) begin
            @(negedge clock);
            if (done0) begin
                doneLat = c;
                break;
            end
        end
        checkOutput("timeout WAIT cycles", 128'(doneLat), 128'd16);
        waitIdle();
        engHang = 1'b0;
`endif

        repeat (5) @(posedge clock);
        checkOutput("engine start count", 128'(startCount), 128'(expStarts));
        checkOutput("final queue empty", 128'(expQ.size()), '0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
